// File: rtl/wb_pkg.sv
// wb_pkg: shared constants and types for the write-back commit unit.
//   rd-source encodings, CSR addresses / reset values, ecall cause code,
//   commit-FSM state encoding and the latched bundle layout.
package wb_pkg;

    localparam logic [2:0] RD_NONE = 3'd0;
    localparam logic [2:0] RD_ALU  = 3'd1;
    localparam logic [2:0] RD_MEM  = 3'd2;
    localparam logic [2:0] RD_LINK = 3'd3;
    localparam logic [2:0] RD_CMP  = 3'd4;
    localparam logic [2:0] RD_CSR  = 3'd5;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    localparam logic [31:0] MSTATUS_RST = 32'h0000_1800;
    localparam logic [31:0] MTVEC_RST   = 32'h0;
    localparam logic [31:0] MEPC_RST    = 32'h0;
    localparam logic [31:0] MCAUSE_RST  = 32'h0;

    localparam logic [31:0] MCAUSE_ECALL_M = 32'd11;

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_COMMIT   = 2'd1;
    localparam logic [1:0] S_WAIT_NPC = 2'd2;

    // Fields needed to form the register-file write after acceptance.
    typedef struct packed {
        logic [2:0]  rdregsrc;
        logic [4:0]  rd;
        logic [31:0] alu_result;
        logic [31:0] mdata;
        logic [31:0] snpc;
        logic        cmp_result;
    } wb_bundle_t;

endpackage

// File: rtl/wb_csr_file.sv
// wb_csr_file: machine CSRs (mstatus, mtvec, mepc, mcause).
//   clk, rst       : clock, synchronous active-high reset
//   raddr_i/rdata_o: combinational read, unknown addresses read 0
//   we_i/waddr_i/wdata_i : CSR write, unknown addresses ignored
//   trap_i/epc_i   : ecall trap, loads mepc and mcause (overrides a same-cycle write)
//   mtvec_o        : current trap vector
module wb_csr_file
    import wb_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] raddr_i,
    output logic [31:0] rdata_o,
    input  logic        we_i,
    input  logic [11:0] waddr_i,
    input  logic [31:0] wdata_i,
    input  logic        trap_i,
    input  logic [31:0] epc_i,
    output logic [31:0] mtvec_o
);

    logic [31:0] mstatus_q, mtvec_q, mepc_q, mcause_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            mstatus_q <= MSTATUS_RST;
            mtvec_q   <= MTVEC_RST;
            mepc_q    <= MEPC_RST;
            mcause_q  <= MCAUSE_RST;
        end else begin
            if (we_i) begin
                case (waddr_i)
                    CSR_MSTATUS: mstatus_q <= wdata_i;
                    CSR_MTVEC:   mtvec_q   <= wdata_i;
                    CSR_MEPC:    mepc_q    <= wdata_i;
                    CSR_MCAUSE:  mcause_q  <= wdata_i;
                    default: ;
                endcase
            end
            // Placed after the write so the trap values win on mepc/mcause.
            if (trap_i) begin
                mepc_q   <= epc_i;
                mcause_q <= MCAUSE_ECALL_M;
            end
        end
    end

    always_comb begin
        rdata_o = 32'h0;
        case (raddr_i)
            CSR_MSTATUS: rdata_o = mstatus_q;
            CSR_MTVEC:   rdata_o = mtvec_q;
            CSR_MEPC:    rdata_o = mepc_q;
            CSR_MCAUSE:  rdata_o = mcause_q;
            default: ;
        endcase
    end

    assign mtvec_o = mtvec_q;

endmodule

// File: rtl/wb_commit.sv
// wb_commit: write-back commit unit at the end of the M->W bundle.
//   clk, rst                 : clock, synchronous active-high reset
//   s_valid/s_ready          : bundle handshake from the W-stage bus
//   dnpc..src2, rdregsrc, csraddr, cmp_result, ecall, rd : bundle fields
//   rf_we/rf_waddr/rf_wdata  : one register-file write per bundle (COMMIT only)
//   npc_valid/npc_ready/npc  : next-PC handshake to the IFU
// Build option: define WB_CSR_EN to include the CSR file, CSR rd source
// and ecall trap; otherwise CSR reads yield 0 and ecall is ignored.
module wb_commit
    import wb_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [31:0] dnpc,
    input  logic [31:0] mdata,
    input  logic [31:0] alu_result,
    input  logic [31:0] snpc,
    input  logic [31:0] pc,
    input  logic [31:0] csr_wdata,
    input  logic [31:0] src2,
    input  logic [2:0]  rdregsrc,
    input  logic [11:0] csraddr,
    input  logic        cmp_result,
    input  logic        ecall,
    input  logic [4:0]  rd,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        npc_valid,
    input  logic        npc_ready,
    output logic [31:0] npc
);

    logic [1:0]  state_q, state_d;
    wb_bundle_t  bnd_q;
    logic [31:0] npc_q, npc_d;
    logic [31:0] csr_rdata;
    logic        accept, in_commit;

    assign s_ready   = (state_q == S_IDLE);
    assign npc_valid = (state_q != S_IDLE);
    assign npc       = npc_q;
    assign accept    = s_valid && s_ready;
    assign in_commit = (state_q == S_COMMIT);

    // src2 is carried on the bus for debug only.
    logic unused_dbg;
    assign unused_dbg = ^src2;

`ifdef WB_CSR_EN
    logic [11:0] csraddr_q;
    logic [31:0] csr_wdata_q, pc_q, mtvec;
    logic        ecall_q;

    wb_csr_file u_csr (
        .clk     (clk),
        .rst     (rst),
        .raddr_i (csraddr_q),
        .rdata_o (csr_rdata),
        .we_i    (in_commit && (bnd_q.rdregsrc == RD_CSR)),
        .waddr_i (csraddr_q),
        .wdata_i (csr_wdata_q),
        .trap_i  (in_commit && ecall_q),
        .epc_i   (pc_q),
        .mtvec_o (mtvec)
    );

    // mtvec is sampled at acceptance, before this bundle can rewrite it.
    assign npc_d = ecall ? mtvec : dnpc;

    always_ff @(posedge clk) begin
        if (rst) begin
            csraddr_q   <= '0;
            csr_wdata_q <= '0;
            pc_q        <= '0;
            ecall_q     <= 1'b0;
        end else if (accept) begin
            csraddr_q   <= csraddr;
            csr_wdata_q <= csr_wdata;
            pc_q        <= pc;
            ecall_q     <= ecall;
        end
    end
`else
    assign csr_rdata = 32'h0;
    assign npc_d     = dnpc;

    logic unused_csr;
    assign unused_csr = ^{pc, csr_wdata, csraddr, ecall};
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (accept)    state_d = S_COMMIT;
            S_COMMIT:   state_d = npc_ready ? S_IDLE : S_WAIT_NPC;
            S_WAIT_NPC: if (npc_ready) state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            bnd_q   <= '0;
            npc_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                bnd_q.rdregsrc   <= rdregsrc;
                bnd_q.rd         <= rd;
                bnd_q.alu_result <= alu_result;
                bnd_q.mdata      <= mdata;
                bnd_q.snpc       <= snpc;
                bnd_q.cmp_result <= cmp_result;
                npc_q            <= npc_d;
            end
        end
    end

    always_comb begin
        rf_wdata = 32'h0;
        case (bnd_q.rdregsrc)
            RD_ALU:  rf_wdata = bnd_q.alu_result;
            RD_MEM:  rf_wdata = bnd_q.mdata;
            RD_LINK: rf_wdata = bnd_q.snpc;
            RD_CMP:  rf_wdata = {31'b0, bnd_q.cmp_result};
            RD_CSR:  rf_wdata = csr_rdata;
            default: ;
        endcase
    end

    // Codes 6-7 fall outside ALU..CSR and therefore never write.
    assign rf_we    = in_commit && (bnd_q.rd != 5'd0) &&
                      (bnd_q.rdregsrc >= RD_ALU) && (bnd_q.rdregsrc <= RD_CSR);
    assign rf_waddr = bnd_q.rd;

endmodule

// File: tb/tb_wb_commit.sv
module tb_wb_commit;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_valid, s_ready;
    logic [31:0] dnpc, mdata, alu_result, snpc, pc, csr_wdata, src2;
    logic [2:0]  rdregsrc;
    logic [11:0] csraddr;
    logic        cmp_result, ecall;
    logic [4:0]  rd;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        npc_valid, npc_ready;
    logic [31:0] npc;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    wb_commit dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
        .dnpc(dnpc), .mdata(mdata), .alu_result(alu_result), .snpc(snpc),
        .pc(pc), .csr_wdata(csr_wdata), .src2(src2), .rdregsrc(rdregsrc),
        .csraddr(csraddr), .cmp_result(cmp_result), .ecall(ecall), .rd(rd),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .npc_valid(npc_valid), .npc_ready(npc_ready), .npc(npc)
    );

    typedef struct {
        logic [31:0] dnpc, mdata, alu, snpc, pc, cwd, src2;
        logic [2:0]  src;
        logic [11:0] ca;
        logic        cmp, ecall;
        logic [4:0]  rd;
    } bnd_t;

    // Reference CSR state: a map from address to value; absent keys read 0.
    logic [31:0] csr_m [int];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        csr_m.delete();
        csr_m[32'h300] = 32'h0000_1800;
        csr_m[32'h305] = 32'h0;
        csr_m[32'h341] = 32'h0;
        csr_m[32'h342] = 32'h0;
    endtask

    function automatic logic [31:0] csr_rd(input logic [11:0] a);
`ifdef WB_CSR_EN
        return csr_m.exists(int'(a)) ? csr_m[int'(a)] : 32'h0;
`else
        return 32'h0;
`endif
    endfunction

    task automatic drive(input bnd_t b);
        dnpc = b.dnpc; mdata = b.mdata; alu_result = b.alu; snpc = b.snpc;
        pc = b.pc; csr_wdata = b.cwd; src2 = b.src2; rdregsrc = b.src;
        csraddr = b.ca; cmp_result = b.cmp; ecall = b.ecall; rd = b.rd;
    endtask

    function automatic bnd_t rand_bnd();
        bnd_t b;
        logic [11:0] addrs [5];
        addrs[0] = 12'h300; addrs[1] = 12'h305; addrs[2] = 12'h341;
        addrs[3] = 12'h342; addrs[4] = 12'($urandom);
        b.dnpc = $urandom; b.mdata = $urandom; b.alu = $urandom; b.snpc = $urandom;
        b.pc = $urandom; b.cwd = $urandom; b.src2 = $urandom;
        b.src = 3'($urandom_range(0, 7));
        b.ca = addrs[$urandom_range(0, 4)];
        b.cmp = 1'($urandom);
        b.ecall = ($urandom_range(0, 3) == 0);
        b.rd = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom);
        return b;
    endfunction

    function automatic bnd_t zero_bnd();
        bnd_t b;
        b.dnpc = 0; b.mdata = 0; b.alu = 0; b.snpc = 0; b.pc = 0; b.cwd = 0;
        b.src2 = 0; b.src = 0; b.ca = 0; b.cmp = 0; b.ecall = 0; b.rd = 0;
        return b;
    endfunction

    // Expected outcome of one bundle, then model state update.
    task automatic predict(input bnd_t b, output logic we, output logic [31:0] data,
                           output logic [31:0] nxt);
        logic [31:0] old;
        old = csr_rd(b.ca);
        case (b.src)
            3'd1: data = b.alu;
            3'd2: data = b.mdata;
            3'd3: data = b.snpc;
            3'd4: data = {31'b0, b.cmp};
            3'd5: data = old;
            default: data = 32'h0;
        endcase
        we = (b.src >= 3'd1 && b.src <= 3'd5) && (b.rd != 5'd0);
`ifdef WB_CSR_EN
        nxt = b.ecall ? csr_rd(12'h305) : b.dnpc;
        if (b.src == 3'd5 && csr_m.exists(int'(b.ca))) csr_m[int'(b.ca)] = b.cwd;
        if (b.ecall) begin
            csr_m[32'h341] = b.pc;
            csr_m[32'h342] = 32'd11;
        end
`else
        nxt = b.dnpc;
`endif
    endtask

    // Issue one bundle (called at a negedge with the unit idle); the IFU
    // holds npc_ready low for d cycles after the commit cycle starts.
    task automatic run(input bnd_t b, input int d, output logic [31:0] wdata_seen);
        logic we;
        logic [31:0] data, nxt;
        predict(b, we, data, nxt);
        wdata_seen = 32'hx;
        chk("s_ready_idle", {31'b0, s_ready}, 32'd1);
        drive(b);
        s_valid = 1'b1;
        @(posedge clk); #1;
        s_valid = 1'b0;
        drive(rand_bnd());
        for (int c = 0; c <= d; c++) begin
            if (c > 0) begin @(posedge clk); #1; end
            npc_ready = (c == d);
            @(negedge clk);
            chk("rf_we", {31'b0, rf_we}, (c == 0) ? {31'b0, we} : 32'd0);
            if (c == 0 && we) begin
                chk("rf_waddr", {27'b0, rf_waddr}, {27'b0, b.rd});
                chk("rf_wdata", rf_wdata, data);
                wdata_seen = rf_wdata;
            end
            chk("npc_valid", {31'b0, npc_valid}, 32'd1);
            chk("npc", npc, nxt);
            chk("s_ready_busy", {31'b0, s_ready}, 32'd0);
        end
        @(posedge clk); #1;
        npc_ready = 1'($urandom);
        @(negedge clk);
        chk("npc_valid_done", {31'b0, npc_valid}, 32'd0);
        chk("s_ready_done", {31'b0, s_ready}, 32'd1);
        chk("rf_we_done", {31'b0, rf_we}, 32'd0);
    endtask

    initial begin
        bnd_t b;
        logic [31:0] ws;
        logic [31:0] exp_mtvec;
        rst = 1'b1; s_valid = 1'b0; npc_ready = 1'b0;
        drive(zero_bnd());
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);

        chk("rst_s_ready", {31'b0, s_ready}, 32'd1);
        chk("rst_rf_we", {31'b0, rf_we}, 32'd0);
        chk("rst_rf_waddr", {27'b0, rf_waddr}, 32'd0);
        chk("rst_rf_wdata", rf_wdata, 32'd0);
        chk("rst_npc_valid", {31'b0, npc_valid}, 32'd0);
        chk("rst_npc", npc, 32'd0);

        // ALU write
        b = zero_bnd(); b.src = 3'd1; b.rd = 5'd5; b.alu = 32'hDEAD_BEEF; b.dnpc = 32'h8000_0004;
        run(b, 0, ws);

        // x0 suppression
        b = zero_bnd(); b.src = 3'd2; b.rd = 5'd0; b.mdata = 32'h1234; b.dnpc = 32'h8000_0008;
        run(b, 0, ws);

        // Preset mtvec, then swap it and read back
        b = zero_bnd(); b.src = 3'd5; b.ca = 12'h305; b.cwd = 32'h8000_0100; b.rd = 5'd1;
        run(b, 0, ws);
        b = zero_bnd(); b.src = 3'd5; b.ca = 12'h305; b.cwd = 32'h8000_0200; b.rd = 5'd7;
        run(b, 1, ws);
`ifdef WB_CSR_EN
        chk("csr_swap_old", ws, 32'h8000_0100);
        exp_mtvec = 32'h8000_0200;
`else
        chk("csr_swap_old", ws, 32'h0);
        exp_mtvec = 32'h0;
`endif
        b = zero_bnd(); b.src = 3'd5; b.ca = 12'h305; b.cwd = 32'h8000_0100; b.rd = 5'd2;
        run(b, 0, ws);
        chk("csr_readback", ws, exp_mtvec);

        // ecall with mtvec = 0x8000_0100, also writing mepc in the same bundle
        b = zero_bnd(); b.ecall = 1'b1; b.pc = 32'h8000_0040; b.dnpc = 32'h8000_0044;
        b.src = 3'd5; b.ca = 12'h341; b.cwd = 32'h5555_5555; b.rd = 5'd0;
        run(b, 2, ws);
        b = zero_bnd(); b.src = 3'd5; b.ca = 12'h341; b.cwd = 32'h0; b.rd = 5'd3;
        run(b, 0, ws);
        b = zero_bnd(); b.src = 3'd5; b.ca = 12'h342; b.cwd = 32'h0; b.rd = 5'd4;
        run(b, 0, ws);

        // Backpressure: IFU not ready for 4 cycles
        b = rand_bnd(); b.src = 3'd3; b.rd = 5'd9;
        run(b, 4, ws);

        for (int i = 0; i < 40; i++) run(rand_bnd(), $urandom_range(0, 3), ws);

        // Reset while waiting on the IFU
        b = zero_bnd(); b.src = 3'd5; b.ca = 12'h300; b.cwd = 32'hFFFF_0000; b.rd = 5'd6;
        drive(b);
        s_valid = 1'b1;
        @(posedge clk); #1;
        s_valid = 1'b0; npc_ready = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("wait_npc_valid", {31'b0, npc_valid}, 32'd1);
        chk("wait_rf_we", {31'b0, rf_we}, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        chk("midrst_npc_valid", {31'b0, npc_valid}, 32'd0);
        chk("midrst_s_ready", {31'b0, s_ready}, 32'd1);
        chk("midrst_rf_we", {31'b0, rf_we}, 32'd0);
        chk("midrst_rf_wdata", rf_wdata, 32'd0);
        chk("midrst_npc", npc, 32'd0);
        b = zero_bnd(); b.src = 3'd5; b.ca = 12'h300; b.cwd = 32'h0; b.rd = 5'd8;
        run(b, 0, ws);
`ifdef WB_CSR_EN
        chk("mstatus_after_rst", ws, 32'h0000_1800);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
